// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops registered in one step, multiply/divide via
// iterative radix-2 engines; valid/ready handshake on both operand and result sides.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state, state_next;
   logic [2*WIDTH-1:0]   acc, step_acc;
   logic [WIDTH-1:0]     opnd;
   logic [3:0]           op_reg;
   logic [SHW-1:0]       count;

   logic                 accept, is_mul, is_div, start_iter;
   logic                 reg_mul, reg_high;
   logic [WIDTH-1:0]     sum, diff, simple_res, iter_res;
   logic                 simple_ovf;
   logic [WIDTH:0]       mul_sum, rem_trial;

   assign accept     = in_valid && (state == IDLE);
   assign is_mul     = (op == 4'd2) || (op == 4'd11);
   assign is_div     = (op == 4'd12) || (op == 4'd13);
   assign start_iter = is_mul || (is_div && (b != '0));
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);

   assign sum  = a + b;
   assign diff = a - b;

   // Single-cycle results; the divide-by-zero cases land here too since they skip the engine
   always_comb begin
      simple_res = '0;
      simple_ovf = 1'b0;
      case (op)
         4'd0: begin
            simple_res = sum;
            simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            simple_res = diff;
            simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         4'd3:  simple_res = a & b;
         4'd4:  simple_res = a | b;
         4'd5:  simple_res = a << b[SHW-1:0];
         4'd6:  simple_res = a >> b[SHW-1:0];
         4'd7:  simple_res = $unsigned($signed(a) >>> b[SHW-1:0]);
         4'd8:  simple_res = a ^ b;
         4'd9:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd10: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
         4'd12: simple_res = '1;
         4'd13: simple_res = a;
         default: simple_res = '0;
      endcase
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   assign reg_mul   = (op_reg == 4'd2) || (op_reg == 4'd11);
   assign reg_high  = (op_reg == 4'd11) || (op_reg == 4'd13);
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
   assign rem_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

   always_comb begin
      step_acc = acc;
      if (reg_mul)
         step_acc = {mul_sum, acc[WIDTH-1:1]};
      else if (rem_trial[WIDTH])
         step_acc = {acc[2*WIDTH-2:0], 1'b0};
      else
         step_acc = {rem_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   assign iter_res = reg_high ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = start_iter ? BUSY : DONE;
         BUSY: if (count == LAST) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The final engine step writes the result directly, so BUSY lasts exactly WIDTH cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         opnd   <= '0;
         op_reg <= '0;
         count  <= '0;
         result <= '0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_reg <= op;
                  count  <= '0;
                  if (start_iter) begin
                     acc  <= {{WIDTH{1'b0}}, (is_mul ? b : a)};
                     opnd <= is_mul ? a : b;
                  end else begin
                     result <= simple_res;
                     zero   <= (simple_res == '0);
                     ovf    <= simple_ovf;
                  end
               end
            end
            BUSY: begin
               acc   <= step_acc;
               count <= count + 1'b1;
               if (count == LAST) begin
                  result <= iter_res;
                  zero   <= (iter_res == '0);
                  ovf    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops scored
// against a plain-arithmetic reference model.
module tb_alu_mc;

   localparam int W = 32;
   localparam int ITER_LAT = W + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [3:0]    op = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          zero;
   logic          ovf;

   int checks = 0;
   int errors = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model straight from the op definitions, using 64-bit arithmetic
   function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic v, output int lat);
      logic [63:0] prod;
      longint      s;
      prod = {32'b0, x} * {32'b0, y};
      v    = 1'b0;
      lat  = 1;
      case (o)
         4'd0: begin r = x + y; s = longint'($signed(x)) + longint'($signed(y));
                     v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd1: begin r = x - y; s = longint'($signed(x)) - longint'($signed(y));
                     v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'd2:  begin r = prod[31:0];  lat = ITER_LAT; end
         4'd3:  r = x & y;
         4'd4:  r = x | y;
         4'd5:  r = x << y[4:0];
         4'd6:  r = x >> y[4:0];
         4'd7:  r = $signed(x) >>> y[4:0];
         4'd8:  r = x ^ y;
         4'd9:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd10: r = (x < y) ? 32'd1 : 32'd0;
         4'd11: begin r = prod[63:32]; lat = ITER_LAT; end
         4'd12: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = (y == 0) ? 1 : ITER_LAT; end
         4'd13: begin r = (y == 0) ? x : x % y;             lat = (y == 0) ? 1 : ITER_LAT; end
         default: r = '0;
      endcase
   endfunction

   // Present one op (in_ready assumed high), count edges until out_valid, leave it in DONE
   task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic z, output logic v, output int lat);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result; z = zero; v = ovf;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (result !== '0)      begin errors++; $display("[TB] FAIL reset_result got %h want 0", result); end
      checks++; if ({zero, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b want 00", {zero, ovf}); end
      reset = 1'b0;
   endtask

   task automatic test_add_ovf();
      logic [W-1:0] r; logic z, v; int lat;
      applyStimulus(4'd0, 32'h7FFF_FFFF, 32'd1, r, z, v, lat);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_result got %h want 80000000", r); end
      checks++; if ({z, v} !== 2'b01)    begin errors++; $display("[TB] FAIL add_flags got z%b o%b want z0 o1", z, v); end
      checks++; if (lat !== 1)           begin errors++; $display("[TB] FAIL add_latency got %0d want 1", lat); end
      retire();
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL add_retire got v%b r%b want v0 r1", out_valid, in_ready); end
   endtask

   task automatic test_sub_hold();
      logic [W-1:0] r; logic z, v; int lat; int bad;
      applyStimulus(4'd1, 32'd5, 32'd5, r, z, v, lat);
      checks++; if (r !== '0)         begin errors++; $display("[TB] FAIL sub_result got %h want 0", r); end
      checks++; if ({z, v} !== 2'b10) begin errors++; $display("[TB] FAIL sub_flags got z%b o%b want z1 o0", z, v); end
      bad = 0;
      in_valid = 1'b1; op = 4'd0; a = 32'h1234; b = 32'h1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== '0 || zero !== 1'b1 || ovf !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL sub_hold_stable got %0d unstable cycles want 0", bad); end
      retire();
   endtask

   task automatic test_shift_cmp();
      logic [W-1:0] r; logic z, v; int lat;
      applyStimulus(4'd7, 32'h8000_0000, 32'h0000_003F, r, z, v, lat);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL sra_result got %h want ffffffff", r); end
      retire();
      applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd1, r, z, v, lat);
      checks++; if (r !== 32'd1) begin errors++; $display("[TB] FAIL slt_result got %h want 1", r); end
      retire();
      applyStimulus(4'd10, 32'hFFFF_FFFF, 32'd1, r, z, v, lat);
      checks++; if (r !== 32'd0 || z !== 1'b1) begin errors++; $display("[TB] FAIL sltu_result got %h z%b want 0 z1", r, z); end
      retire();
   endtask

   task automatic test_mul();
      logic [W-1:0] r; logic z, v; int lat;
      applyStimulus(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, v, lat);
      checks++; if (r !== 32'd1) begin errors++; $display("[TB] FAIL mul_result got %h want 1", r); end
      checks++; if (lat !== ITER_LAT) begin errors++; $display("[TB] FAIL mul_latency got %0d want %0d", lat, ITER_LAT); end
      retire();
      applyStimulus(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, v, lat);
      checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mulhu_result got %h want fffffffe", r); end
      retire();
   endtask

   task automatic test_div();
      logic [W-1:0] r; logic z, v; int lat;
      applyStimulus(4'd12, 32'd100, 32'd7, r, z, v, lat);
      checks++; if (r !== 32'd14 || lat !== ITER_LAT) begin errors++; $display("[TB] FAIL divu got %0d lat %0d want 14 lat %0d", r, lat, ITER_LAT); end
      retire();
      applyStimulus(4'd13, 32'd100, 32'd7, r, z, v, lat);
      checks++; if (r !== 32'd2) begin errors++; $display("[TB] FAIL remu got %0d want 2", r); end
      retire();
      applyStimulus(4'd12, 32'd9, 32'd0, r, z, v, lat);
      checks++; if (r !== 32'hFFFF_FFFF || lat !== 1) begin errors++; $display("[TB] FAIL divu_by0 got %h lat %0d want ffffffff lat 1", r, lat); end
      retire();
      applyStimulus(4'd13, 32'd9, 32'd0, r, z, v, lat);
      checks++; if (r !== 32'd9 || lat !== 1) begin errors++; $display("[TB] FAIL remu_by0 got %h lat %0d want 9 lat 1", r, lat); end
      retire();
   endtask

   task automatic test_reset_midbusy();
      logic [W-1:0] r; logic z, v; int lat;
      op = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if ({out_valid, in_ready} !== 2'b01 || result !== '0)
         begin errors++; $display("[TB] FAIL midbusy_reset got v%b r%b res %h want v0 r1 res 0", out_valid, in_ready, result); end
      applyStimulus(4'd0, 32'd2, 32'd3, r, z, v, lat);
      checks++; if (r !== 32'd5 || lat !== 1) begin errors++; $display("[TB] FAIL post_reset_add got %0d lat %0d want 5 lat 1", r, lat); end
      retire();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] r; logic z, v; int lat;
      applyStimulus(4'd0, 32'd1, 32'd1, r, z, v, lat);
      op = 4'd8; a = 32'hF0F0_1234; b = 32'h0FF0_FFFF; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_retire got v%b r%b want v0 r1", out_valid, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'hFF00_EDCB)
         begin errors++; $display("[TB] FAIL b2b_xor got v%b %h want v1 ff00edcb", out_valid, result); end
      retire();
   endtask

   task automatic test_random();
      logic [W-1:0] r, x, y, er; logic z, v, ev; int lat, elat; logic [3:0] o;
      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom_range(0, 15));
         x = $urandom;
         case ($urandom_range(0, 4))
            0: y = '0;
            1: y = 32'($urandom_range(1, 40));
            2: y = 32'hFFFF_FFFF;
            default: y = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
         model(o, x, y, er, ev, elat);
         applyStimulus(o, x, y, r, z, v, lat);
         checks++; if (r !== er) begin errors++; $display("[TB] FAIL rand_result op%0d a=%h b=%h got %h want %h", o, x, y, r, er); end
         checks++; if (z !== (er == '0)) begin errors++; $display("[TB] FAIL rand_zero op%0d got %b want %b", o, z, (er == '0)); end
         checks++; if (v !== ev) begin errors++; $display("[TB] FAIL rand_ovf op%0d a=%h b=%h got %b want %b", o, x, y, v, ev); end
         checks++; if (lat !== elat) begin errors++; $display("[TB] FAIL rand_latency op%0d got %0d want %0d", o, lat, elat); end
         retire();
      end
   endtask

   task automatic checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_sub_hold();
      test_shift_cmp();
      test_mul();
      test_div();
      test_reset_midbusy();
      test_back_to_back();
      test_random();
      checkOutput();
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath's execute stage. Keeps the single-cycle ALU's operation codes 0-5 and adds right shifts, XOR, compares, high multiply and unsigned divide/remainder. Multiply and divide run as iterative radix-2 engines. Operands enter and results leave through valid/ready handshakes, so the control FSM can stall on long operations.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept a new operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation select
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result
- zero  out  1  result == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)

## Operation
- Op codes:
  - 0 ADD
  - 1 SUB
  - 2 MUL low WIDTH bits
  - 3 AND
  - 4 OR
  - 5 SLL
  - 6 SRL
  - 7 SRA
  - 8 XOR
  - 9 SLT signed
  - 10 SLTU
  - 11 MULHU (high WIDTH bits of unsigned product)
  - 12 DIVU quotient
  - 13 REMU remainder
  - 14-15 result 0
- Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- SLT/SLTU return 1 or 0, zero-extended.
- ovf on ADD: both operand signs equal and result sign differs. ovf on SUB: operand signs differ and result sign differs from a.
- States:
  - IDLE: in_ready = 1.
  - BUSY: iterative engine active.
  - DONE: out_valid = 1; result, zero, ovf held stable.
- IDLE, accept (in_valid & in_ready), simple op (0,1,3-11 except 2/11, 14,15): result computed combinationally and registered; go to DONE.
- IDLE, accept, op 2/11/12/13: load the engine, counter = 0; go to BUSY.
- IDLE, accept, DIVU/REMU with b == 0: no BUSY phase, go straight to DONE. Quotient = all ones; remainder = a.
- BUSY: one engine step per cycle.
  - Multiply: shift-add over 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per step.
  - After WIDTH steps, go to DONE.
- DONE & out_ready: go to IDLE.
- No new operation is accepted while in BUSY or DONE. Operands are captured at accept, so a/b/op may change afterwards.
- zero and ovf are registered with result.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, ovf = 0, counter = 0.
- Accept at edge N. Simple op or divide-by-zero: out_valid high from edge N+1.
- Accept at edge N. Iterative op: out_valid high from edge N+WIDTH+1 (WIDTH BUSY cycles).
- Output handshake at edge M: out_valid low and in_ready high from edge M+1. Earliest next accept is edge M+1.
- Throughput: one op per 2 cycles minimum for simple ops; no accept/retire overlap.
- out_ready held low: DONE persists indefinitely and outputs do not change.
- in_valid while busy is ignored and the operands are not latched; the producer must hold them.
- Reset asserted mid-BUSY or in DONE: the operation is aborted. All outputs return to reset values at the next edge and no result is produced.
- Arithmetic is modulo 2^WIDTH. MUL and MULHU come from the same full 2*WIDTH-bit product.

## Test plan
- Reset, then ADD a=0x7FFFFFFF b=1 -> out_valid 1 cycle after accept; result 0x80000000, ovf=1, zero=0.
- SUB a=5 b=5 -> result 0, zero=1, ovf=0. Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout.
- SRA a=0x80000000 b=0x0000003F (amount 31) -> 0xFFFFFFFF. SLT a=0xFFFFFFFF b=1 -> 1. SLTU with the same operands -> 0.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF -> result 0x00000001 after exactly 33 cycles. MULHU with the same operands -> 0xFFFFFFFE.
- DIVU a=100 b=7 -> 14 after WIDTH+1 cycles. REMU -> 2. DIVU a=9 b=0 -> 0xFFFFFFFF after 1 cycle. REMU a=9 b=0 -> 9.
- Start MUL, assert reset at BUSY cycle 10 -> next edge: out_valid=0, in_ready=1, result=0. A following ADD 2+3 -> 5 with normal latency.
